// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and parameter check for the serial adder
package adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic bit width_ok(input int w, input int d);
    return (w >= 2) && (d >= 1) && (d <= w) && ((w % d) == 0);
  endfunction
endpackage

// File: rtl/fa_slice.sv
// fa_slice: combinational DIGIT-bit ripple adder built from full-adder bits
module fa_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);
  logic [DIGIT:0] w_c;
  assign w_c[0] = c_in;
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
  end
  assign c_out    = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];
endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle adder processing DIGIT bits per clock with start/busy/done handshake
module serial_adder_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_adder_n: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_opa, r_opb, r_acc, w_acc_next;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_s;
  logic             w_c_out, w_c_msb, w_last;
  fa_slice #(.DIGIT(DIGIT)) u_slice (
    .a       (r_opa[DIGIT-1:0]),
    .b       (r_opb[DIGIT-1:0]),
    .c_in    (r_carry),
    .s       (w_s),
    .c_out   (w_c_out),
    .c_msb_in(w_c_msb)
  );
  // New digit enters the accumulator at the top; after STEPS shifts it holds the full sum.
  assign w_acc_next = WIDTH'({w_s, r_acc} >> DIGIT);
  always_comb begin
    w_last = (r_state == ST_RUN) && (r_cnt == CW'(STEPS - 1));
    w_next = r_state == ST_IDLE ? (start ? ST_RUN : ST_IDLE)
           : r_state == ST_RUN  ? (w_last ? ST_DONE : ST_RUN)
           : ST_IDLE;
    busy   = r_state == ST_RUN;
    done   = r_state == ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_opa   <= a;
        r_opb   <= b;
        r_carry <= cin;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_opa   <= r_opa >> DIGIT;
        r_opb   <= r_opb >> DIGIT;
        r_acc   <= w_acc_next;
        r_carry <= w_c_out;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          sum      <= w_acc_next;
          cout     <= w_c_out;
          overflow <= w_c_msb ^ w_c_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: directed checks of serial_adder_n across several WIDTH/DIGIT configurations
module tb_serial_adder_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a, b;
  logic cin;
  logic [4:0] start_v, busy_v, done_v, cout_v, ovf_v;
  logic [7:0] sum_v [5];
  logic [3:0] s4;
  int steps_of [5] = '{8, 2, 4, 4, 1};
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .overflow(ovf_v[0]));
  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .overflow(ovf_v[1]));
  serial_adder_n #(.WIDTH(8), .DIGIT(2)) u2 (.clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .overflow(ovf_v[2]));
  serial_adder_n #(.WIDTH(4), .DIGIT(1)) u3 (.clk(clk), .rst(rst), .start(start_v[3]), .a(a[3:0]), .b(b[3:0]), .cin(cin),
    .busy(busy_v[3]), .done(done_v[3]), .sum(s4), .cout(cout_v[3]), .overflow(ovf_v[3]));
  serial_adder_n #(.WIDTH(8), .DIGIT(8)) u4 (.clk(clk), .rst(rst), .start(start_v[4]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[4]), .done(done_v[4]), .sum(sum_v[4]), .cout(cout_v[4]), .overflow(ovf_v[4]));
  assign sum_v[3] = {4'h0, s4};

  typedef struct {
    int         i;
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       c, o;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Starts instance i from IDLE, checks busy/done timing and that sum holds until the final edge.
  task automatic run(input int i, input logic [7:0] av, input logic [7:0] bv, input logic ci, input bit poke,
                     output logic [7:0] rs, output logic rc, output logic ro);
    logic [7:0] prev;
    int n;
    prev = sum_v[i];
    n = steps_of[i];
    a = av; b = bv; cin = ci; start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= n; k++) begin
      chk("busy", 32'(busy_v[i]), 32'd1);
      chk("early_done", 32'(done_v[i]), 32'd0);
      chk("sum_hold", 32'(sum_v[i]), 32'(prev));
      if (poke && k == 1) begin
        start_v[i] = 1'b1;
        a = 8'h11;
      end else start_v[i] = 1'b0;
      @(negedge clk);
    end
    start_v[i] = 1'b0;
    chk("done", 32'(done_v[i]), 32'd1);
    chk("busy_off", 32'(busy_v[i]), 32'd0);
    rs = sum_v[i]; rc = cout_v[i]; ro = ovf_v[i];
    @(negedge clk);
    chk("done_pulse", 32'(done_v[i]), 32'd0);
  endtask

  initial begin
    logic [7:0] rs;
    logic rc, ro;
    logic [4:0] e;
    tbl[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{0, 8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0};
    tbl[2] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[5] = '{2, 8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{2, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{4, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0};
    tbl[8] = '{4, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    tbl[9] = '{3, 8'h0F, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    start_v = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst_busy", 32'(busy_v[i]), 32'd0);
      chk("rst_done", 32'(done_v[i]), 32'd0);
      chk("rst_sum", 32'(sum_v[i]), 32'd0);
      chk("rst_cout", 32'(cout_v[i]), 32'd0);
      chk("rst_ovf", 32'(ovf_v[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    a = 8'h55; b = 8'h0F; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    chk("midrst_sum", 32'(sum_v[0]), 32'd0);
    chk("midrst_done", 32'(done_v[0]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done_v[0] | busy_v[0]), 32'd0);
    end
    run(0, 8'h01, 8'h01, 1'b0, 1'b0, rs, rc, ro);
    chk("after_rst_sum", 32'(rs), 32'h02);
    chk("after_rst_cout", 32'(rc), 32'd0);
    for (int t = 0; t < 10; t++) begin
      run(tbl[t].i, tbl[t].a, tbl[t].b, tbl[t].ci, 1'b0, rs, rc, ro);
      chk($sformatf("vec%0d_sum", t), 32'(rs), 32'(tbl[t].s));
      chk($sformatf("vec%0d_cout", t), 32'(rc), 32'(tbl[t].c));
      chk($sformatf("vec%0d_ovf", t), 32'(ro), 32'(tbl[t].o));
    end
    run(2, 8'h3C, 8'hC3, 1'b1, 1'b1, rs, rc, ro);
    chk("poke_sum", 32'(rs), 32'h00);
    chk("poke_cout", 32'(rc), 32'd1);
    chk("poke_ovf", 32'(ro), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("poke_idle", 32'({busy_v[2], done_v[2]}), 32'd0);
      @(negedge clk);
    end
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          run(3, 8'(x), 8'(y), 1'(c), 1'b0, rs, rc, ro);
          e = 5'(x + y + c);
          chk($sformatf("exh_%0h_%0h_%0d", x, y, c), 32'({rc, rs[3:0]}), 32'(e));
          chk("exh_ovf", 32'(ro), 32'((x[3] == y[3]) && (e[3] != x[3])));
        end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
